// File: rtl/dot_product_engine_if.sv
// Port bundle of the dot-product engine: command/status, shared memory read
// port (A and B answer the same address) and the valid/ready result channel.
interface dot_product_engine_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+ADDR_WIDTH
);
  logic                  start;
  logic [ADDR_WIDTH:0]   len;
  logic                  busy;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_address;
  logic [DATA_WIDTH-1:0] a_data;
  logic [DATA_WIDTH-1:0] b_data;
  logic [ACC_WIDTH-1:0]  result;
  logic                  result_valid;
  logic                  result_ready;

  modport slave (
    input  start, len, a_data, b_data, result_ready,
    output busy, rd_en, rd_address, result, result_valid
  );

  modport master (
    output start, len, a_data, b_data, result_ready,
    input  busy, rd_en, rd_address, result, result_valid
  );
endinterface

// File: rtl/dot_product_engine.sv
// Streams addresses 0..len-1 to the A/B vector memories, multiplies returned
// element pairs and accumulates them; result offered on a valid/ready port.
module dot_product_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+ADDR_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  dot_product_engine_if.slave bus
);
  localparam int PROD_W = 2*DATA_WIDTH;
  localparam int STAGES = 1;
  localparam logic [ADDR_WIDTH:0]   MAX_LEN  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr, last_addr, last_nxt;
  logic                  drain_cnt;
  logic [STAGES:0]       vld_pipe;
  logic [PROD_W-1:0]     mul, prod;
  logic [ACC_WIDTH-1:0]  acc;

  // Lengths above the address space clamp to a full sweep; len==2^AW also
  // lands on the all-ones last address through the wrap of the low bits.
  assign last_nxt = (bus.len > MAX_LEN) ? {ADDR_WIDTH{1'b1}}
                                        : bus.len[ADDR_WIDTH-1:0] - ADDR_ONE;
  assign mul = {{DATA_WIDTH{1'b0}}, bus.a_data} * {{DATA_WIDTH{1'b0}}, bus.b_data};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    bus.busy         = 1'b1;
    bus.rd_en        = 1'b0;
    bus.result_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_nxt = (bus.len == '0) ? DONE : READ;
      end
      READ: begin
        bus.rd_en = 1'b1;
        if (addr == last_addr) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt) state_nxt = DONE;
      end
      DONE: begin
        bus.result_valid = 1'b1;
        if (bus.result_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.rd_address = addr;
  assign bus.result     = acc;

  // vld_pipe[0]: memory data valid this cycle; vld_pipe[1]: product valid.
  // Memory outputs are Z/stale outside those cycles, so they are never used.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr      <= '0;
      last_addr <= '0;
      drain_cnt <= 1'b0;
      vld_pipe  <= '0;
      prod      <= '0;
      acc       <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], bus.rd_en};
      prod     <= vld_pipe[0] ? mul : '0;
      if (vld_pipe[STAGES])
        acc <= acc + {{(ACC_WIDTH-PROD_W){1'b0}}, prod};
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            acc       <= '0;
            addr      <= '0;
            last_addr <= last_nxt;
          end
        end
        READ: begin
          drain_cnt <= 1'b0;
          if (addr != last_addr) addr <= addr + ADDR_ONE;
        end
        DRAIN:   drain_cnt <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dot_product_engine.sv
// Directed + randomized bench for dot_product_engine with a registered-read
// memory model and an arithmetic dot-product reference.
module tb_dot_product_engine;
  logic clk, rst_n;
  int n_vec = 0;
  int n_err = 0;

  dot_product_engine_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ACC_WIDTH(20)) bus ();

  dot_product_engine #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ACC_WIDTH(20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem_a [16];
  logic [7:0] mem_b [16];
  logic [7:0] a_q = 'x;
  logic [7:0] b_q = 'x;

  always @(posedge clk) begin
    if (bus.rd_en === 1'b1) begin
      a_q <= mem_a[bus.rd_address];
      b_q <= mem_b[bus.rd_address];
    end
  end
  assign bus.a_data = a_q;
  assign bus.b_data = b_q;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] model(input int n);
    int eff;
    logic [31:0] s;
    eff = (n > 16) ? 16 : n;
    s = 0;
    for (int i = 0; i < eff; i++) s += int'(mem_a[i]) * int'(mem_b[i]);
    return s[19:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 8'($urandom);
      mem_b[i] = 8'($urandom);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},  bus.busy, 0);
    chk({tag, "_rden"},  bus.rd_en, 0);
    chk({tag, "_addr"},  bus.rd_address, 0);
    chk({tag, "_res"},   bus.result, 0);
    chk({tag, "_valid"}, bus.result_valid, 0);
  endtask

  // Called at a negedge in IDLE with result_ready=1; checks full cycle timing.
  task automatic run(input int n, input logic [19:0] exp, input string tag);
    int eff;
    eff = (n > 16) ? 16 : n;
    bus.start = 1'b1;
    bus.len   = 5'(n);
    @(negedge clk);
    bus.start = 1'b0;
    if (eff == 0) begin
      chk({tag, "_rden"},  bus.rd_en, 0);
      chk({tag, "_valid"}, bus.result_valid, 1);
      chk({tag, "_res"},   bus.result, exp);
    end else begin
      for (int k = 1; k <= eff; k++) begin
        chk({tag, "_rd_en"}, bus.rd_en, 1);
        chk({tag, "_addr"},  bus.rd_address, k-1);
        @(negedge clk);
      end
      chk({tag, "_drain_rden"}, bus.rd_en, 0);
      chk({tag, "_drain_busy"}, bus.busy, 1);
      @(negedge clk);
      chk({tag, "_drain_valid"}, bus.result_valid, 0);
      @(negedge clk);
      chk({tag, "_valid"}, bus.result_valid, 1);
      chk({tag, "_res"},   bus.result, exp);
    end
    @(negedge clk);
    chk({tag, "_post_valid"}, bus.result_valid, 0);
    chk({tag, "_post_busy"},  bus.busy, 0);
    chk({tag, "_post_rden"},  bus.rd_en, 0);
    chk({tag, "_post_res"},   bus.result, exp);
  endtask

  initial begin
    logic [19:0] exp_v;
    int n;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.len = '0;
    bus.result_ready = 1'b0;
    fill_rand();

    // Reset with random inputs, including start
    repeat (3) begin
      bus.start        = 1'($urandom);
      bus.len          = 5'($urandom);
      bus.result_ready = 1'($urandom);
      @(negedge clk);
    end
    chk_reset_vals("reset");
    bus.start = 1'b0;
    bus.result_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_idle_busy", bus.busy, 0);
    chk("reset_idle_valid", bus.result_valid, 0);

    // Basic run
    mem_a[0] = 8'h11; mem_a[1] = 8'h22;
    mem_b[0] = 8'h03; mem_b[1] = 8'h02;
    run(2, 20'h77, "basic");

    // Full length, max values, and clamped length
    for (int i = 0; i < 16; i++) begin mem_a[i] = 8'hFF; mem_b[i] = 8'hFF; end
    run(16, 20'hFE010, "full16");
    run(20, 20'hFE010, "clamp20");

    // Zero length
    run(0, 20'h0, "zero");

    // Backpressure with ignored starts in READ and DONE
    fill_rand();
    exp_v = model(6);
    bus.result_ready = 1'b0;
    bus.start = 1'b1; bus.len = 5'd6;
    @(negedge clk);               // cycle 1
    bus.start = 1'b0;
    @(negedge clk);               // cycle 2
    bus.start = 1'b1; bus.len = 5'd3;
    @(negedge clk);               // cycle 3
    bus.start = 1'b0;
    chk("bp_read_addr", bus.rd_address, 2);
    repeat (6) @(negedge clk);    // cycle 9
    chk("bp_valid", bus.result_valid, 1);
    chk("bp_res", bus.result, exp_v);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.start = (i == 3);
      bus.len   = 5'd2;
      chk("bp_hold_valid", bus.result_valid, 1);
      chk("bp_hold_res", bus.result, exp_v);
      chk("bp_hold_rden", bus.rd_en, 0);
    end
    bus.start = 1'b0;
    bus.result_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", bus.result_valid, 0);
    chk("bp_release_busy", bus.busy, 0);
    chk("bp_release_res", bus.result, exp_v);
    fill_rand();
    n = $urandom_range(1, 16);
    run(n, model(n), "bp_next");

    // Reset mid-READ at address 3
    fill_rand();
    bus.start = 1'b1; bus.len = 5'd8;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);    // cycle 4
    chk("midrst_addr", bus.rd_address, 3);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    mem_a[0] = 8'h11; mem_a[1] = 8'h22;
    mem_b[0] = 8'h03; mem_b[1] = 8'h02;
    run(2, 20'h77, "post_rst");

    // Randomized runs against the reference
    repeat (6) begin
      fill_rand();
      n = $urandom_range(0, 31);
      run(n, model(n), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
